// File: rtl/myfilter_pkg.sv
// Shared filter-datapath definitions: sample width and the output buffer
// occupancy states.
package myfilter_pkg;

  localparam int DATABITS = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/buffer_mem.sv
// Sample storage for ext_out_buffer: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module buffer_mem
  import myfilter_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATABITS-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [DATABITS-1:0] rd_data
);

  logic [DATABITS-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end else begin
      mem_r[wr_addr] <= mem_r[wr_addr];
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/ext_out_buffer.sv
// First-word-fall-through buffer between the filter output and a ready/valid
// consumer, with sticky overflow flag and saturating drop counter.
module ext_out_buffer
  import myfilter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATABITS-1:0]      ext_in,
  input  logic                     extvalid_in,
  input  logic                     clr_in,
  output logic [DATABITS-1:0]      m_data_out,
  output logic                     m_valid_out,
  input  logic                     m_ready_in,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_out,
  output logic [7:0]               drops_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fifo_state_t         state_r, state_s;
  logic [AW-1:0]       wr_ptr_r, wr_ptr_s;
  logic [AW-1:0]       rd_ptr_r, rd_ptr_s;
  logic [CW-1:0]       count_r, count_s;
  logic [DATABITS-1:0] data_r, data_s;
  logic                valid_r, valid_s;
  logic                overflow_r, overflow_s;
  logic [7:0]          drops_r, drops_s;
  logic                do_read_s, do_write_s, do_drop_s;
  logic [DATABITS-1:0] mem_rd_data_s;

  buffer_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (do_write_s),
    .wr_addr (wr_ptr_r),
    .wr_data (ext_in),
    .rd_addr (rd_ptr_s),
    .rd_data (mem_rd_data_s)
  );

  // Next-state, pointer, occupancy and error-status logic
  always_comb begin
    state_s    = state_r;
    wr_ptr_s   = wr_ptr_r;
    rd_ptr_s   = rd_ptr_r;
    count_s    = count_r;
    overflow_s = overflow_r;
    drops_s    = drops_r;
    do_read_s  = valid_r && m_ready_in && !clr_in;
    do_write_s = 1'b0;
    do_drop_s  = 1'b0;

    case (state_r)
      EMPTY:   do_write_s = extvalid_in && !clr_in;
      PARTIAL: do_write_s = extvalid_in && !clr_in;
      FULL: begin
        do_write_s = extvalid_in && do_read_s;
        do_drop_s  = extvalid_in && !do_read_s && !clr_in;
      end
      default: do_write_s = 1'b0;
    endcase

    if (clr_in) begin
      state_s    = EMPTY;
      wr_ptr_s   = PTR_ZERO;
      rd_ptr_s   = PTR_ZERO;
      count_s    = CNT_ZERO;
      overflow_s = 1'b0;
      drops_s    = 8'd0;
    end else begin
      if (do_write_s) begin
        wr_ptr_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (do_read_s) begin
        rd_ptr_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      if (do_write_s && !do_read_s) begin
        count_s = count_r + CNT_ONE;
      end else if (do_read_s && !do_write_s) begin
        count_s = count_r - CNT_ONE;
      end else begin
        count_s = count_r;
      end
      if (do_drop_s && (drops_r != 8'd255)) begin
        drops_s = drops_r + 8'd1;
      end else begin
        drops_s = drops_r;
      end
      overflow_s = overflow_r | do_drop_s;
      if (count_s == CNT_ZERO) begin
        state_s = EMPTY;
      end else if (count_s == CNT_FULL) begin
        state_s = FULL;
      end else begin
        state_s = PARTIAL;
      end
    end
  end

  // Next head sample; bypass ext_in when it lands in the slot about to become head
  always_comb begin
    data_s  = {DATABITS{1'b0}};
    valid_s = (count_s != CNT_ZERO);
    if (count_s == CNT_ZERO) begin
      data_s = {DATABITS{1'b0}};
    end else if (do_write_s && (wr_ptr_r == rd_ptr_s)) begin
      data_s = ext_in;
    end else begin
      data_s = mem_rd_data_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      data_r     <= {DATABITS{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      drops_r    <= 8'd0;
    end else begin
      state_r    <= state_s;
      wr_ptr_r   <= wr_ptr_s;
      rd_ptr_r   <= rd_ptr_s;
      count_r    <= count_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      overflow_r <= overflow_s;
      drops_r    <= drops_s;
    end
  end

  assign m_data_out   = data_r;
  assign m_valid_out  = valid_r;
  assign count_out    = count_r;
  assign overflow_out = overflow_r;
  assign drops_out    = drops_r;

endmodule

// File: tb/tb_ext_out_buffer.sv
// Directed self-checking bench for ext_out_buffer with DEPTH=8.
module tb_ext_out_buffer;
  import myfilter_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                clk_en = 1'b1;
  logic                rst_n = 1'b0;
  logic [DATABITS-1:0] ext_in = '0;
  logic                extvalid_in = 1'b0;
  logic                clr_in = 1'b0;
  logic [DATABITS-1:0] m_data_out;
  logic                m_valid_out;
  logic                m_ready_in = 1'b0;
  logic [CW-1:0]       count_out;
  logic                overflow_out;
  logic [7:0]          drops_out;

  int checks = 0;
  int errors = 0;
  logic [DATABITS-1:0] q[$];
  logic [DATABITS-1:0] head;
  logic                rd;

  ext_out_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ext_in       (ext_in),
    .extvalid_in  (extvalid_in),
    .clr_in       (clr_in),
    .m_data_out   (m_data_out),
    .m_valid_out  (m_valid_out),
    .m_ready_in   (m_ready_in),
    .count_out    (count_out),
    .overflow_out (overflow_out),
    .drops_out    (drops_out)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data is compared only when a valid sample is expected
  task automatic check_all(input string tag, input logic v, input logic [DATABITS-1:0] d,
                           input logic [CW-1:0] c, input logic o, input logic [7:0] dr);
    checks++;
    assert (m_valid_out === v) else begin
      errors++; $error("FAIL %s valid: observed=%0b expected=%0b", tag, m_valid_out, v);
    end
    if (v) begin
      checks++;
      assert (m_data_out === d) else begin
        errors++; $error("FAIL %s data: observed=%0d expected=%0d", tag, m_data_out, d);
      end
    end
    checks++;
    assert (count_out === c) else begin
      errors++; $error("FAIL %s count: observed=%0d expected=%0d", tag, count_out, c);
    end
    checks++;
    assert (overflow_out === o) else begin
      errors++; $error("FAIL %s overflow: observed=%0b expected=%0b", tag, overflow_out, o);
    end
    checks++;
    assert (drops_out === dr) else begin
      errors++; $error("FAIL %s drops: observed=%0d expected=%0d", tag, drops_out, dr);
    end
  endtask

  initial begin
    // Reset state
    #12;
    checks++;
    assert (m_data_out === '0) else begin
      errors++; $error("FAIL reset_data: observed=%0d expected=0", m_data_out);
    end
    check_all("reset", 1'b0, '0, '0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Three writes with consumer stalled, then drain in order
    extvalid_in = 1'b1; ext_in = 16'd5; step();
    check_all("w5", 1'b1, 16'd5, CW'(1), 1'b0, 8'd0);
    ext_in = 16'd7; step();
    ext_in = 16'd9; step();
    extvalid_in = 1'b0;
    check_all("w3_hold", 1'b1, 16'd5, CW'(3), 1'b0, 8'd0);
    step();
    check_all("w3_stable", 1'b1, 16'd5, CW'(3), 1'b0, 8'd0);
    m_ready_in = 1'b1; step();
    check_all("rd7", 1'b1, 16'd7, CW'(2), 1'b0, 8'd0);
    step();
    check_all("rd9", 1'b1, 16'd9, CW'(1), 1'b0, 8'd0);
    step();
    check_all("rd_empty", 1'b0, '0, CW'(0), 1'b0, 8'd0);
    step();
    check_all("no_underflow", 1'b0, '0, CW'(0), 1'b0, 8'd0);

    // Overfill: 10 writes into 8 slots
    m_ready_in = 1'b0; extvalid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ext_in = DATABITS'(100 + i); step();
    end
    extvalid_in = 1'b0;
    check_all("ovf_full", 1'b1, 16'd100, CW'(8), 1'b1, 8'd2);
    m_ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_all("ovf_rd", 1'b1, DATABITS'(100 + i), CW'(8 - i), 1'b1, 8'd2);
      step();
    end
    check_all("ovf_drained", 1'b0, '0, CW'(0), 1'b1, 8'd2);

    // Simultaneous write and read while FULL
    m_ready_in = 1'b0; extvalid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ext_in = DATABITS'(200 + i); step();
    end
    check_all("full2", 1'b1, 16'd200, CW'(8), 1'b1, 8'd2);
    m_ready_in = 1'b1; ext_in = 16'd250; step();
    extvalid_in = 1'b0;
    check_all("full_rw", 1'b1, 16'd201, CW'(8), 1'b1, 8'd2);
    for (int k = 0; k < 7; k++) begin
      check_all("full_rw_rd", 1'b1, DATABITS'(201 + k), CW'(8 - k), 1'b1, 8'd2);
      step();
    end
    check_all("full_rw_last", 1'b1, 16'd250, CW'(1), 1'b1, 8'd2);
    step();
    check_all("full_rw_empty", 1'b0, '0, CW'(0), 1'b1, 8'd2);

    // Clear overrides concurrent write and read
    m_ready_in = 1'b0; extvalid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext_in = DATABITS'(400 + i); step();
    end
    check_all("pre_clr", 1'b1, 16'd400, CW'(4), 1'b1, 8'd2);
    clr_in = 1'b1; m_ready_in = 1'b1; ext_in = 16'd499; step();
    check_all("clr", 1'b0, '0, CW'(0), 1'b0, 8'd0);
    clr_in = 1'b0; extvalid_in = 1'b0; m_ready_in = 1'b0; step();
    check_all("post_clr", 1'b0, '0, CW'(0), 1'b0, 8'd0);

    // 20 writes with interleaved reads; pointers wrap twice
    for (int i = 0; i < 20; i++) begin
      extvalid_in = 1'b1; ext_in = DATABITS'(300 + i);
      m_ready_in = ((i % 3) != 0);
      rd = m_ready_in && (q.size() > 0);
      step();
      if (rd) void'(q.pop_front());
      q.push_back(DATABITS'(300 + i));
      head = q[0];
      check_all("wrap", 1'b1, head, CW'(q.size()), 1'b0, 8'd0);
    end
    extvalid_in = 1'b0; m_ready_in = 1'b1;
    for (int k = 0; k < 16 && q.size() > 0; k++) begin
      step();
      void'(q.pop_front());
      head = (q.size() > 0) ? q[0] : '0;
      check_all("wrap_drain", q.size() > 0, head, CW'(q.size()), 1'b0, 8'd0);
    end

    // Asynchronous reset with clock stopped mid-transfer
    m_ready_in = 1'b0; extvalid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ext_in = DATABITS'(600 + i); step();
    end
    extvalid_in = 1'b0; m_ready_in = 1'b1; step();
    check_all("pre_rst", 1'b1, 16'd601, CW'(2), 1'b0, 8'd0);
    @(negedge clk);
    clk_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (m_data_out === '0) else begin
      errors++; $error("FAIL async_rst_data: observed=%0d expected=0", m_data_out);
    end
    check_all("async_rst", 1'b0, '0, CW'(0), 1'b0, 8'd0);
    #10;
    rst_n = 1'b1;
    m_ready_in = 1'b0;
    #2;
    clk_en = 1'b1;
    step();
    check_all("post_rst", 1'b0, '0, CW'(0), 1'b0, 8'd0);
    extvalid_in = 1'b1; ext_in = 16'd77; step();
    extvalid_in = 1'b0;
    check_all("post_rst_wr", 1'b1, 16'd77, CW'(1), 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
